// File: rtl/bcd_display_scan.sv
// Three-digit multiplexed 7-segment driver for a 12-bit BCD word. Digit updates are
// taken from a shadow register only at frame boundaries, so one frame never mixes two values.
module bcd_display_scan #(
    parameter int REFRESH_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] bcd,
    input  logic        load,
    input  logic        lz_en,
    output logic [6:0]  seg,
    output logic [2:0]  an,
    output logic        frame,
    output logic [1:0]  dbg_state,
    output logic        dbg_pending
);

    localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_ERR   = 7'h06;

    localparam logic [2:0] AN_OFF   = 3'b111;
    localparam logic [2:0] AN_UNITS = 3'b110;
    localparam logic [2:0] AN_TENS  = 3'b101;
    localparam logic [2:0] AN_HUND  = 3'b011;

    typedef enum logic [1:0] {
        S_U = 2'd0,
        S_T = 2'd1,
        S_H = 2'd2
    } state_t;

    state_t           state;
    logic [DIV_W-1:0] div;
    logic [11:0]      shadow;
    logic [11:0]      active;
    logic             pending;

    logic             tick;
    logic             boundary;
    logic [3:0]       digit;
    logic             blank;
    logic [2:0]       an_next;
    logic [6:0]       seg_next;

    // Active-low {g,f,e,d,c,b,a}; non-decimal nibbles show "E".
    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = SEG_ERR;
        endcase
        return s;
    endfunction

    assign tick     = (div == DIV_LAST);
    assign boundary = tick && (state == S_H);

    // Units never blank; tens blank only when the hundreds digit is blank too.
    always_comb begin
        digit   = active[3:0];
        blank   = 1'b0;
        an_next = AN_UNITS;
        case (state)
            S_T: begin
                digit   = active[7:4];
                blank   = lz_en && (active[11:8] == 4'd0) && (active[7:4] == 4'd0);
                an_next = AN_TENS;
            end
            S_H: begin
                digit   = active[11:8];
                blank   = lz_en && (active[11:8] == 4'd0);
                an_next = AN_HUND;
            end
            default: begin
                digit   = active[3:0];
                blank   = 1'b0;
                an_next = AN_UNITS;
            end
        endcase
        seg_next = blank ? SEG_BLANK : decode(digit);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div     <= '0;
            state   <= S_U;
            shadow  <= '0;
            active  <= '0;
            pending <= 1'b0;
            frame   <= 1'b0;
            seg     <= SEG_BLANK;
            an      <= AN_OFF;
        end else begin
            div <= tick ? '0 : div + 1'b1;

            if (tick) begin
                case (state)
                    S_U:     state <= S_T;
                    S_T:     state <= S_H;
                    default: state <= S_U;
                endcase
            end

            frame <= boundary;
            seg   <= seg_next;
            an    <= an_next;

            // A load landing on the boundary bypasses the shadow so it shows in the new frame.
            if (load) begin
                shadow <= bcd;
            end
            if (boundary && load) begin
                active  <= bcd;
                pending <= 1'b0;
            end else if (boundary && pending) begin
                active  <= shadow;
                pending <= 1'b0;
            end else if (load) begin
                pending <= 1'b1;
            end
        end
    end

    assign dbg_state   = state;
    assign dbg_pending = pending;

endmodule

// File: tb/tb_bcd_display_scan.sv
// Directed bench for bcd_display_scan: each expected frame is queued as three
// {anode, segment} slots and checked as the scan moves onto each digit.
module tb_bcd_display_scan;

    localparam int RD = 4;
    localparam int WAIT_LIMIT = 60;

    logic        clk;
    logic        rst;
    logic [11:0] bcd;
    logic        load;
    logic        lz_en;
    logic [6:0]  seg;
    logic [2:0]  an;
    logic        frame;
    logic [1:0]  dbg_state;
    logic        dbg_pending;

    logic [9:0]  exp_q[$];
    logic [2:0]  seen_an;
    int          n_vec;
    int          n_err;

    bcd_display_scan #(.REFRESH_DIV(RD)) dut (
        .clk         (clk),
        .rst         (rst),
        .bcd         (bcd),
        .load        (load),
        .lz_en       (lz_en),
        .seg         (seg),
        .an          (an),
        .frame       (frame),
        .dbg_state   (dbg_state),
        .dbg_pending (dbg_pending)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0: return 7'h40;
            4'd1: return 7'h79;
            4'd2: return 7'h24;
            4'd3: return 7'h30;
            4'd4: return 7'h19;
            4'd5: return 7'h12;
            4'd6: return 7'h02;
            4'd7: return 7'h78;
            4'd8: return 7'h00;
            4'd9: return 7'h10;
            default: return 7'h06;
        endcase
    endfunction

    // Queue the three slots one frame of value v should show.
    function automatic void push_frame(input logic [11:0] v, input logic lz);
        logic h_blank;
        logic t_blank;
        h_blank = lz && (v[11:8] == 4'd0);
        t_blank = h_blank && (v[7:4] == 4'd0);
        exp_q.push_back({3'b110, seg_of(v[3:0])});
        exp_q.push_back({3'b101, t_blank ? 7'h7F : seg_of(v[7:4])});
        exp_q.push_back({3'b011, h_blank ? 7'h7F : seg_of(v[11:8])});
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard pop: compare the slot currently on the outputs.
    task automatic check_now(input string tag);
        logic [9:0] e;
        if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $error("FAIL %s: observed an=%b seg=%h expected queue entry, queue empty", tag, an, seg);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_an"}, 16'(an), 16'(e[9:7]));
            check({tag, "_seg"}, 16'(seg), 16'(e[6:0]));
        end
        seen_an = an;
    endtask

    task automatic check_slots(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            int w;
            w = 0;
            while (an === seen_an && w < WAIT_LIMIT) begin
                @(negedge clk);
                w++;
            end
            if (w >= WAIT_LIMIT) begin
                n_vec++;
                n_err++;
                $error("FAIL %s_timeout: observed no anode change, expected one within %0d cycles", tag, WAIT_LIMIT);
            end
            check_now(tag);
        end
    endtask

    task automatic wait_frame(input string tag);
        int w;
        w = 0;
        while (frame !== 1'b1 && w < WAIT_LIMIT) begin
            @(negedge clk);
            w++;
        end
        check({tag, "_frame"}, 16'(frame), 16'd1);
        @(negedge clk);
        check({tag, "_frame_width"}, 16'(frame), 16'd0);
    endtask

    // Driver: called at a negedge, strobe is sampled on the next rising edge.
    task automatic load_value(input logic [11:0] v);
        bcd  = v;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    initial begin
        n_vec   = 0;
        n_err   = 0;
        rst     = 1'b1;
        bcd     = '0;
        load    = 1'b0;
        lz_en   = 1'b0;
        seen_an = 3'b111;

        // 1. reset, then 255 loaded at cycle 2 appears only after the first frame pulse
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_seg", 16'(seg), 16'h7F);
        check("reset_an", 16'(an), 16'h7);
        check("reset_frame", 16'(frame), 16'd0);
        check("reset_state", 16'(dbg_state), 16'd0);
        check("reset_pending", 16'(dbg_pending), 16'd0);
        rst = 1'b0;
        push_frame(12'h000, 1'b0);
        @(negedge clk);
        check_now("t1_first_units");
        load_value(12'h255);
        check("t1_pending", 16'(dbg_pending), 16'd1);
        check_slots("t1_old", 2);
        wait_frame("t1");
        push_frame(12'h255, 1'b0);
        check_slots("t1_255", 3);

        // 2. leading-zero blanking on 007, then blanking switched off
        lz_en = 1'b1;
        load_value(12'h007);
        wait_frame("t2a");
        push_frame(12'h007, 1'b1);
        check_slots("t2_lz", 3);
        lz_en = 1'b0;
        wait_frame("t2b");
        push_frame(12'h007, 1'b0);
        check_slots("t2_nolz", 3);

        // 3. all-zero value and a non-decimal tens nibble
        lz_en = 1'b1;
        load_value(12'h000);
        wait_frame("t3a");
        push_frame(12'h000, 1'b1);
        check_slots("t3_zero", 3);
        load_value(12'h0A5);
        wait_frame("t3b");
        push_frame(12'h0A5, 1'b1);
        check_slots("t3_err", 3);

        // 4. two loads mid-frame: old value finishes, only the last one is shown
        wait_frame("t4a");
        push_frame(12'h0A5, 1'b1);
        check_slots("t4_old_u", 1);
        load_value(12'h128);
        @(negedge clk);
        load_value(12'h064);
        check_slots("t4_old_th", 2);
        wait_frame("t4b");
        push_frame(12'h064, 1'b1);
        check_slots("t4_new", 3);

        // 5. load on the hundreds tick overrides an earlier pending load
        wait_frame("t5a");
        push_frame(12'h064, 1'b1);
        check_slots("t5_u", 1);
        load_value(12'h333);
        check_slots("t5_th", 2);
        @(negedge clk);
        @(negedge clk);
        bcd  = 12'h981;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        check("t5_frame", 16'(frame), 16'd1);
        check("t5_pending", 16'(dbg_pending), 16'd0);
        push_frame(12'h981, 1'b1);
        check_slots("t5_new", 3);

        // 6. asynchronous reset in S_T with div=2
        wait_frame("t6");
        push_frame(12'h981, 1'b1);
        check_slots("t6_pre", 2);
        @(posedge clk);
        #2;
        check("t6_state_before", 16'(dbg_state), 16'd1);
        rst = 1'b1;
        #1;
        check("t6_rst_seg", 16'(seg), 16'h7F);
        check("t6_rst_an", 16'(an), 16'h7);
        check("t6_rst_frame", 16'(frame), 16'd0);
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        check("t6_rst_state", 16'(dbg_state), 16'd0);
        rst     = 1'b0;
        seen_an = 3'b111;
        push_frame(12'h000, 1'b1);
        check_slots("t6_restart", 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
